// File: rtl/hht_pkg.sv
// Shared definitions for the HHT gather engine: datapath widths, the default
// CPU stream address and the FIFO entry layout.
package hht_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    // CPU load address that maps onto the gathered-vector stream
    localparam logic [ADDR_W-1:0] HHT_ADDR_DEFAULT = 32'd126;

    // One gathered element: the value and the vector address it came from
    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [ADDR_W-1:0] vaddr;
    } hht_entry_t;

    // Occupancy counter width able to represent 0..depth inclusive
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : hht_pkg

// File: rtl/hht_fifo.sv
// Synchronous FIFO of hht_entry_t with a combinationally visible head entry.
// Reset is synchronous, active-low, and clears pointers and occupancy only.
module hht_fifo
    import hht_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          i_push,
    input  hht_entry_t                    i_push_entry,
    input  logic                          i_pop,
    output hht_entry_t                    o_head,
    output logic [fifo_cnt_w(DEPTH)-1:0]  o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);

    hht_entry_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A push into a full FIFO is accepted only if a pop frees a slot the same cycle
    assign w_do_push = i_push && (!w_full || i_pop);
    assign w_do_pop  = i_pop && !w_empty;

    // Storage write; entries carry no reset since occupancy tracks validity
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : hht_fifo

// File: rtl/hht_gather_ctrl.sv
// HHT gather engine: walks a column-index array, fetches the addressed
// dense-vector elements through a two-stage pipeline into a small FIFO, and
// presents the FIFO as a stream at one CPU load address.
// Optional feature macro: HHT_BOUNDS_CHECK_EN -- when defined, indices at or
// beyond V_LEN push a zero value (the vector address is still reported).
module hht_gather_ctrl
    import hht_pkg::*;
#(
    parameter logic [ADDR_W-1:0] HHT_ADDR   = HHT_ADDR_DEFAULT,
    parameter int                FIFO_DEPTH = 8,
    parameter int                V_LEN      = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [ADDR_W-1:0]  wdata_col_base,
    input  logic [ADDR_W-1:0]  v_values_base,
    input  logic [DATA_W-1:0]  csize,
    output logic [ADDR_W-1:0]  addr1,
    input  logic [DATA_W-1:0]  dataIn1,
    output logic [ADDR_W-1:0]  addr2,
    input  logic [DATA_W-1:0]  dataIn2,
    input  logic               RD,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               hht,
    output logic [ADDR_W-1:0]  regaddr1,
    output logic [ADDR_W-1:0]  regaddr2,
    output logic [DATA_W-1:0]  rdata,
    output logic [ADDR_W-1:0]  adata
);

    localparam int CW = fifo_cnt_w(FIFO_DEPTH);

    // Reject configurations the occupancy arithmetic cannot support
    generate
        if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("hht_gather_ctrl: FIFO_DEPTH must be a power of two >= 4");
        end
        if (V_LEN < 1) begin : g_bad_vlen
            $error("hht_gather_ctrl: V_LEN must be positive");
        end
    endgenerate

    // Stage 1 state: index counter and the captured column index
    logic [DATA_W-1:0]  r_idx;
    logic [DATA_W-1:0]  r_col_q;
    logic               r_v1;
    logic [ADDR_W-1:0]  r_regaddr1;
    logic [ADDR_W-1:0]  r_regaddr2;

    logic [ADDR_W-1:0]  w_addr1;
    logic [ADDR_W-1:0]  w_addr2;
    logic [31:0]        w_occupancy;
    logic               w_fire;
    logic               w_pop;
    logic [CW-1:0]      w_fifo_count;
    hht_entry_t         w_push_entry;
    hht_entry_t         w_head;

    // Memory addresses are pure functions of the pipeline registers
    assign w_addr1 = wdata_col_base + r_idx;
    assign w_addr2 = v_values_base + r_col_q;

    // Count the in-flight stage-1 entry so a fetch can never overflow the FIFO
    assign w_occupancy = 32'(w_fifo_count) + {31'd0, r_v1};
    assign w_fire      = (r_idx < csize) && (w_occupancy < 32'(FIFO_DEPTH));

    // Only a strobe to the stream address with data available consumes an entry
    assign w_pop = RD && (cpu_addr == HHT_ADDR) && (w_fifo_count != '0);

    // Stage 2 builds the FIFO entry from the vector read
    always_comb begin
        w_push_entry       = '0;
        w_push_entry.vaddr = w_addr2;
`ifdef HHT_BOUNDS_CHECK_EN
        w_push_entry.value = (r_col_q >= 32'(V_LEN)) ? '0 : dataIn2;
`else
        w_push_entry.value = dataIn2;
`endif
    end

    // Pipeline registers: stage-1 fetch capture and stage-2 push address record
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_idx      <= '0;
            r_col_q    <= '0;
            r_v1       <= 1'b0;
            r_regaddr1 <= '0;
            r_regaddr2 <= '0;
        end else begin
            r_v1 <= w_fire;
            if (w_fire) begin
                r_col_q    <= dataIn1;
                r_regaddr1 <= w_addr1;
                r_idx      <= r_idx + 32'd1;
            end
            if (r_v1) begin
                r_regaddr2 <= w_addr2;
            end
        end
    end

    hht_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk          (Clk),
        .Rst          (Rst),
        .i_push       (r_v1),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_count      (w_fifo_count)
    );

    assign addr1    = w_addr1;
    assign addr2    = w_addr2;
    assign regaddr1 = r_regaddr1;
    assign regaddr2 = r_regaddr2;
    assign hht      = w_pop;
    // Head data is only exposed on an accepted stream read
    assign rdata    = w_pop ? w_head.value : '0;
    assign adata    = w_pop ? w_head.vaddr : '0;

endmodule : hht_gather_ctrl

// File: tb/tb_hht_gather_ctrl.sv
// Directed bench for hht_gather_ctrl: basic gather, mid-stream reset,
// completion, backpressure, address miss and the bounds-check behaviour.
module tb_hht_gather_ctrl;
    import hht_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] wdata_col_base, v_values_base, csize;
    logic [31:0] addr1, dataIn1, addr2, dataIn2;
    logic        RD;
    logic [31:0] cpu_addr;
    logic        hht;
    logic [31:0] regaddr1, regaddr2, rdata, adata;

    logic [31:0] col_mem [512];
    logic [31:0] vec_mem [512];

    int n_checks = 0;
    int n_fail   = 0;
    int n_hht;

    always #5 Clk = ~Clk;

    assign dataIn1 = (addr1 < 32'd512) ? col_mem[addr1[8:0]] : 32'hDEAD_BEEF;
    assign dataIn2 = (addr2 < 32'd512) ? vec_mem[addr2[8:0]] : 32'hDEAD_BEEF;

    hht_gather_ctrl #(
        .HHT_ADDR   (32'd126),
        .FIFO_DEPTH (8),
        .V_LEN      (16)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .wdata_col_base (wdata_col_base),
        .v_values_base  (v_values_base),
        .csize          (csize),
        .addr1          (addr1),
        .dataIn1        (dataIn1),
        .addr2          (addr2),
        .dataIn2        (dataIn2),
        .RD             (RD),
        .cpu_addr       (cpu_addr),
        .hht            (hht),
        .regaddr1       (regaddr1),
        .regaddr2       (regaddr2),
        .rdata          (rdata),
        .adata          (adata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Vector address of the k-th element of the stream starting at cbase
    function automatic logic [31:0] exp_vaddr(input logic [31:0] cbase, input int k);
        logic [31:0] a;
        a = cbase + 32'(k);
        return 32'd2 + col_mem[a[8:0]];
    endfunction

    function automatic logic [31:0] exp_value(input logic [31:0] cbase, input int k);
        logic [31:0] a;
        logic [31:0] va;
        a  = cbase + 32'(k);
        va = 32'd2 + col_mem[a[8:0]];
`ifdef HHT_BOUNDS_CHECK_EN
        if (col_mem[a[8:0]] >= 32'd16) return 32'd0;
`endif
        return vec_mem[va[8:0]];
    endfunction

    initial begin
        for (int a = 0; a < 512; a++) begin
            col_mem[a] = 32'(a % 16);
            vec_mem[a] = 32'(1000 + a);
        end
        col_mem[180] = 15; col_mem[181] = 2; col_mem[182] = 11;
        col_mem[400] = 20;
        vec_mem[2]  = 7;  vec_mem[3]  = 93; vec_mem[4]  = 68; vec_mem[5]  = 80;
        vec_mem[6]  = 90; vec_mem[7]  = 15; vec_mem[8]  = 4;  vec_mem[9]  = 8;
        vec_mem[10] = 35; vec_mem[11] = 81; vec_mem[12] = 45; vec_mem[13] = 52;
        vec_mem[14] = 48; vec_mem[15] = 69; vec_mem[16] = 100; vec_mem[17] = 34;

        // ---------------- reset state ----------------
        Rst = 1'b0; wdata_col_base = 180; v_values_base = 2; csize = 230;
        RD = 1'b1; cpu_addr = 126;
        step(); step(); step();
        chk("rst_hht", {31'd0, hht}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_adata", adata, 32'd0);
        chk("rst_regaddr1", regaddr1, 32'd0);
        chk("rst_regaddr2", regaddr2, 32'd0);
        chk("rst_addr1", addr1, 32'd180);
        chk("rst_addr2", addr2, 32'd2);

        // ---------------- basic gather ----------------
        Rst = 1'b1;
        step();  // E0
        chk("e0_hht", {31'd0, hht}, 32'd0);
        chk("e0_regaddr1", regaddr1, 32'd180);
        step();  // E1: first element pushed, visible now
        chk("pop0_hht", {31'd0, hht}, 32'd1);
        chk("pop0_rdata", rdata, 32'd34);
        chk("pop0_adata", adata, 32'd17);
        chk("pop0_regaddr2", regaddr2, 32'd17);
        step();
        chk("pop1_rdata", rdata, 32'd68);
        chk("pop1_adata", adata, 32'd4);
        step();
        chk("pop2_rdata", rdata, 32'd52);
        chk("pop2_adata", adata, 32'd13);
        for (int k = 3; k < 50; k++) begin
            step();
            chk($sformatf("stream%0d_hht", k), {31'd0, hht}, 32'd1);
            chk($sformatf("stream%0d_rdata", k), rdata, exp_value(32'd180, k));
            chk($sformatf("stream%0d_adata", k), adata, exp_vaddr(32'd180, k));
        end

        // ---------------- reset mid-stream ----------------
        Rst = 1'b0;
        step();
        chk("mid_rst_hht", {31'd0, hht}, 32'd0);
        chk("mid_rst_addr1", addr1, 32'd180);
        chk("mid_rst_regaddr1", regaddr1, 32'd0);
        step();
        Rst = 1'b1;
        step();
        chk("restart_e0_hht", {31'd0, hht}, 32'd0);
        step();
        chk("restart_hht", {31'd0, hht}, 32'd1);
        chk("restart_rdata", rdata, 32'd34);
        chk("restart_adata", adata, 32'd17);

        // ---------------- completion ----------------
        Rst = 1'b0; csize = 3;
        step(); step();
        Rst = 1'b1;
        n_hht = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (hht) n_hht++;
        end
        chk("done_hht_cycles", 32'(n_hht), 32'd3);
        chk("done_hht_low", {31'd0, hht}, 32'd0);
        chk("done_addr1", addr1, 32'd183);

        // ---------------- backpressure ----------------
        Rst = 1'b0; csize = 230; RD = 1'b0;
        step(); step();
        Rst = 1'b1;
        for (int c = 0; c < 20; c++) step();
        chk("bp_hht", {31'd0, hht}, 32'd0);
        chk("bp_addr1", addr1, 32'd188);
        chk("bp_regaddr1", regaddr1, 32'd187);
        chk("bp_regaddr2", regaddr2, exp_vaddr(32'd180, 7));
        RD = 1'b1;
        #1;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("bp%0d_hht", k), {31'd0, hht}, 32'd1);
            chk($sformatf("bp%0d_rdata", k), rdata, exp_value(32'd180, k));
            chk($sformatf("bp%0d_adata", k), adata, exp_vaddr(32'd180, k));
            step();
        end

        // ---------------- address miss ----------------
        cpu_addr = 125;
        #1;
        chk("miss_hht", {31'd0, hht}, 32'd0);
        chk("miss_rdata", rdata, 32'd0);
        chk("miss_adata", adata, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("miss%0d_hht", c), {31'd0, hht}, 32'd0);
        end
        cpu_addr = 126;
        #1;
        chk("after_miss_hht", {31'd0, hht}, 32'd1);
        chk("after_miss_rdata", rdata, exp_value(32'd180, 12));
        chk("after_miss_adata", adata, exp_vaddr(32'd180, 12));

        // ---------------- bounds check ----------------
        Rst = 1'b0; wdata_col_base = 400; csize = 1;
        step(); step();
        Rst = 1'b1;
        step(); step();
        chk("oob_hht", {31'd0, hht}, 32'd1);
        chk("oob_adata", adata, 32'd22);
`ifdef HHT_BOUNDS_CHECK_EN
        chk("oob_rdata", rdata, 32'd0);
`else
        chk("oob_rdata", rdata, 32'd1022);
`endif
        step();
        chk("oob_end_hht", {31'd0, hht}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hht_gather_ctrl
